// File: rtl/lvds_rx_framer.sv
// DDR LVDS receive framer: assembles 32-bit I/Q frames, locks on sync bits.
// Define LVDS_RX_ERR_CNT_EN to build the saturating sync-error counter.
module lvds_rx_framer #(
   parameter int SYNC_LOSS_LIMIT = 3,
   parameter int ERR_CNT_W       = 16
) (
   input  logic                 i_ddr_clk,
   input  logic                 i_rst_b,
   input  logic [1:0]           i_ddr_data,
   input  logic                 i_rx_enable,
   input  logic                 i_fifo_full,
   input  logic                 i_clear_status,
   output logic                 o_fifo_write_clk,
   output logic                 o_fifo_push,
   output logic [31:0]          o_fifo_data,
   output logic                 o_rx_state_bit,
   output logic                 o_sync_err,
   output logic                 o_overflow,
   output logic [ERR_CNT_W-1:0] o_err_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HUNT,
      S_LOCKED
   } state_e;

   localparam logic [3:0] LIMIT   = 4'(SYNC_LOSS_LIMIT);
   localparam logic [4:0] ARM_RUN = 5'd16;

   state_e      state_q, state_d;
   logic [29:0] shift_q, shift_d;
   logic [4:0]  zero_run_q, zero_run_d;
   logic        armed_q, armed_d;
   logic [3:0]  bad_cnt_q, bad_cnt_d;
   logic [3:0]  phase_q, phase_d;
   logic        push_q, push_d;
   logic [31:0] data_q, data_d;
   logic        sync_err_q, sync_err_d;
   logic        overflow_q, overflow_d;

   logic [31:0] word;
   logic        is_valid;
   logic        is_idle;
   logic        good;

   assign word     = {shift_q, i_ddr_data};
   assign is_valid = (word[31:30] == 2'b10) && (word[15:14] == 2'b01);
   assign is_idle  = (word == 32'd0);

   always_comb begin
      shift_d    = word;
      zero_run_d = 5'd0;
      if (i_ddr_data == 2'b00) begin
         zero_run_d = (zero_run_q == ARM_RUN) ? ARM_RUN
                                              : zero_run_q + 5'd1;
      end
      state_d    = state_q;
      armed_d    = armed_q;
      bad_cnt_d  = bad_cnt_q;
      phase_d    = phase_q;
      push_d     = 1'b0;
      data_d     = data_q;
      sync_err_d = 1'b0;
      overflow_d = i_clear_status ? 1'b0 : overflow_q;
      good       = 1'b0;

      if (!i_rx_enable) begin
         state_d   = S_IDLE;
         armed_d   = 1'b0;
         bad_cnt_d = 4'd0;
         phase_d   = 4'd0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_HUNT;
               phase_d = 4'd0;
            end
            S_HUNT: begin
               if (phase_q == 4'd0) begin
                  // A nonzero pair after a long zero run marks frame start
                  if (armed_q || (zero_run_q >= ARM_RUN)) begin
                     armed_d = 1'b1;
                     if (i_ddr_data != 2'b00) phase_d = 4'd1;
                  end
               end else begin
                  phase_d = phase_q + 4'd1;
                  if (phase_q == 4'd15) begin
                     if (is_valid) begin
                        good    = 1'b1;
                        state_d = S_LOCKED;
                     end else begin
                        sync_err_d = 1'b1;
                        armed_d    = 1'b0;
                     end
                  end
               end
            end
            S_LOCKED: begin
               phase_d = phase_q + 4'd1;
               if (phase_q == 4'd15) begin
                  if (is_valid) begin
                     good      = 1'b1;
                     bad_cnt_d = 4'd0;
                  end else if (is_idle) begin
                     bad_cnt_d = 4'd0;
                  end else begin
                     sync_err_d = 1'b1;
                     if (bad_cnt_q + 4'd1 == LIMIT) begin
                        state_d   = S_HUNT;
                        armed_d   = 1'b0;
                        bad_cnt_d = 4'd0;
                     end else begin
                        bad_cnt_d = bad_cnt_q + 4'd1;
                     end
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
               phase_d = 4'd0;
            end
         endcase
      end

      if (good) begin
         if (i_fifo_full) begin
            overflow_d = 1'b1;
         end else begin
            push_d = 1'b1;
            data_d = word;
         end
      end
   end

   always_ff @(posedge i_ddr_clk) begin
      if (!i_rst_b) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         zero_run_q <= '0;
         armed_q    <= 1'b0;
         bad_cnt_q  <= '0;
         phase_q    <= '0;
         push_q     <= 1'b0;
         data_q     <= '0;
         sync_err_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         zero_run_q <= zero_run_d;
         armed_q    <= armed_d;
         bad_cnt_q  <= bad_cnt_d;
         phase_q    <= phase_d;
         push_q     <= push_d;
         data_q     <= data_d;
         sync_err_q <= sync_err_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef LVDS_RX_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (sync_err_d) begin
         if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end else if (i_clear_status) begin
         err_cnt_d = '0;
      end
   end

   always_ff @(posedge i_ddr_clk) begin
      if (!i_rst_b) err_cnt_q <= '0;
      else          err_cnt_q <= err_cnt_d;
   end

   assign o_err_count = err_cnt_q;
`else
   assign o_err_count = '0;
`endif

   assign o_fifo_write_clk = i_ddr_clk;
   assign o_fifo_push      = push_q;
   assign o_fifo_data      = data_q;
   assign o_rx_state_bit   = (state_q == S_LOCKED);
   assign o_sync_err       = sync_err_q;
   assign o_overflow       = overflow_q;

endmodule
